// File: rtl/mem_wb_stage.sv
// Memory stage and MEM/WB pipeline register: 256x8 data RAM, write-back mux,
// sticky halt detection. Registered outputs double as the EX forwarding source.
module mem_wb_stage #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              write_mem_i,
    input  logic              read_mem_i,
    input  logic              write_reg_i,
    input  logic [DATA_W-1:0] aluOut_i,
    input  logic [DATA_W-1:0] dataD_i,
    input  logic [2:0]        reg1_i,
    input  logic [3:0]        opcode_i,
    output logic              write_reg_o,
    output logic [2:0]        reg_dst_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              halt_o
);

    localparam int          DEPTH     = 2 ** DATA_W;
    localparam logic [3:0]  OP_HALT   = 4'hF;

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    logic              r_write_reg;
    logic [2:0]        r_reg_dst;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_halt;

    logic              w_store_en;
    logic              w_is_halt;
    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] w_wb_next;

    // Reset gates the store too, so a store coinciding with reset is dropped.
    assign w_store_en = write_mem_i & ~stall_i & ~r_halt & ~reset;
    assign w_is_halt  = (opcode_i == OP_HALT);
    assign w_rd_data  = r_mem[aluOut_i];
    assign w_wb_next  = read_mem_i ? w_rd_data : aluOut_i;

    // RAM is never cleared; the non-blocking write gives read-before-write.
    always_ff @(posedge clk) begin
        if (w_store_en) begin
            r_mem[aluOut_i] <= dataD_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write_reg <= 1'b0;
            r_reg_dst   <= 3'd0;
            r_wb_data   <= '0;
            r_halt      <= 1'b0;
        end else if (!stall_i) begin
            r_write_reg <= write_reg_i & ~r_halt;
            r_reg_dst   <= reg1_i;
            r_wb_data   <= w_wb_next;
            if (w_is_halt) begin
                r_halt <= 1'b1;
            end
        end
    end

    assign write_reg_o = r_write_reg;
    assign reg_dst_o   = r_reg_dst;
    assign wb_data_o   = r_wb_data;
    assign halt_o      = r_halt;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed table-driven bench for mem_wb_stage, with hand-written reset sequences.
module tb_mem_wb_stage;

    logic       clk;
    logic       reset;
    logic       stall_i;
    logic       write_mem_i;
    logic       read_mem_i;
    logic       write_reg_i;
    logic [7:0] aluOut_i;
    logic [7:0] dataD_i;
    logic [2:0] reg1_i;
    logic [3:0] opcode_i;
    logic       write_reg_o;
    logic [2:0] reg_dst_o;
    logic [7:0] wb_data_o;
    logic       halt_o;

    int n_tests;
    int n_fail;

    typedef struct {
        logic       wm;
        logic       rm;
        logic       wr;
        logic [7:0] alu;
        logic [7:0] dd;
        logic [2:0] r1;
        logic [3:0] op;
        logic       st;
        logic       e_wr;
        logic [2:0] e_dst;
        logic [7:0] e_wb;
        logic       e_halt;
    } vec_t;

    vec_t vecs[$];

    mem_wb_stage #(.DATA_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall_i     (stall_i),
        .write_mem_i (write_mem_i),
        .read_mem_i  (read_mem_i),
        .write_reg_i (write_reg_i),
        .aluOut_i    (aluOut_i),
        .dataD_i     (dataD_i),
        .reg1_i      (reg1_i),
        .opcode_i    (opcode_i),
        .write_reg_o (write_reg_o),
        .reg_dst_o   (reg_dst_o),
        .wb_data_o   (wb_data_o),
        .halt_o      (halt_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_wr, input logic [2:0] e_dst,
                              input logic [7:0] e_wb, input logic e_halt);
        check({tag, ".write_reg"}, {7'd0, write_reg_o}, {7'd0, e_wr});
        check({tag, ".reg_dst"},   {5'd0, reg_dst_o},   {5'd0, e_dst});
        check({tag, ".wb_data"},   wb_data_o,           e_wb);
        check({tag, ".halt"},      {7'd0, halt_o},      {7'd0, e_halt});
    endtask

    task automatic drive(input logic wm, input logic rm, input logic wr, input logic [7:0] alu,
                         input logic [7:0] dd, input logic [2:0] r1, input logic [3:0] op,
                         input logic st);
        write_mem_i = wm;
        read_mem_i  = rm;
        write_reg_i = wr;
        aluOut_i    = alu;
        dataD_i     = dd;
        reg1_i      = r1;
        opcode_i    = op;
        stall_i     = st;
    endtask

    task automatic add(input logic wm, input logic rm, input logic wr, input logic [7:0] alu,
                       input logic [7:0] dd, input logic [2:0] r1, input logic [3:0] op,
                       input logic st, input logic e_wr, input logic [2:0] e_dst,
                       input logic [7:0] e_wb, input logic e_halt);
        vec_t v;
        v.wm = wm; v.rm = rm; v.wr = wr; v.alu = alu; v.dd = dd; v.r1 = r1;
        v.op = op; v.st = st; v.e_wr = e_wr; v.e_dst = e_dst; v.e_wb = e_wb;
        v.e_halt = e_halt;
        vecs.push_back(v);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        drive(0, 0, 0, 8'h00, 8'h00, 3'd0, 4'h0, 0);

        //  wm rm wr alu    dd     r1 op    st | wr dst wb     halt
        add(1, 0, 0, 8'h3C, 8'hA5, 0, 4'h0, 0,   0, 0, 8'h3C, 0);  // store A5 @3C
        add(0, 1, 1, 8'h3C, 8'h00, 3, 4'h0, 0,   1, 3, 8'hA5, 0);  // back-to-back load
        add(0, 0, 1, 8'h7E, 8'h00, 5, 4'h0, 0,   1, 5, 8'h7E, 0);  // ALU passthrough
        add(1, 0, 0, 8'h10, 8'h11, 0, 4'h0, 0,   0, 0, 8'h10, 0);  // mem[10]=11
        add(1, 1, 1, 8'h10, 8'h22, 1, 4'h0, 0,   1, 1, 8'h11, 0);  // read-before-write
        add(0, 1, 1, 8'h10, 8'h00, 2, 4'h0, 0,   1, 2, 8'h22, 0);  // new data visible
        add(1, 0, 0, 8'h40, 8'h33, 0, 4'h0, 0,   0, 0, 8'h40, 0);  // mem[40]=33
        add(0, 0, 1, 8'h5C, 8'h00, 7, 4'h0, 0,   1, 7, 8'h5C, 0);
        for (int i = 0; i < 3; i++)                                 // stalled store + halt op
            add(1, 1, 1, 8'h40, 8'hFF, 4, 4'hF, 1, 1, 7, 8'h5C, 0);
        add(1, 1, 1, 8'h40, 8'hFF, 4, 4'h0, 0,   1, 4, 8'h33, 0);  // released: old data read
        add(0, 1, 1, 8'h40, 8'h00, 4, 4'h0, 0,   1, 4, 8'hFF, 0);  // store completed
        add(1, 0, 0, 8'h50, 8'h5A, 0, 4'h0, 0,   0, 0, 8'h50, 0);  // mem[50]=5A
        add(0, 0, 1, 8'h99, 8'h00, 2, 4'hF, 0,   1, 2, 8'h99, 1);  // halt captured normally
        add(1, 0, 0, 8'h50, 8'hEE, 0, 4'h0, 0,   0, 0, 8'h50, 1);  // store suppressed
        add(0, 0, 1, 8'h12, 8'h00, 6, 4'h0, 0,   0, 6, 8'h12, 1);  // write-back suppressed
        add(0, 1, 1, 8'h50, 8'h00, 3, 4'h0, 0,   0, 3, 8'h5A, 1);  // mem[50] unchanged

        repeat (2) @(posedge clk);
        #1;
        check_outs("reset_init", 0, 0, 8'h00, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].wm, vecs[i].rm, vecs[i].wr, vecs[i].alu, vecs[i].dd,
                  vecs[i].r1, vecs[i].op, vecs[i].st);
            @(posedge clk);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].e_wr, vecs[i].e_dst,
                       vecs[i].e_wb, vecs[i].e_halt);
            @(negedge clk);
        end

        // mid-cycle reset while a store to 3C is presented
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1, 0, 1, 8'h3C, 8'h00, 3'd5, 4'h0, 0);
        #1;
        check_outs("reset_async", 0, 0, 8'h00, 0);
        @(posedge clk);
        #1;
        check_outs("reset_hold", 0, 0, 8'h00, 0);
        @(negedge clk);
        reset = 1'b0;

        drive(0, 1, 1, 8'h3C, 8'h00, 3'd3, 4'h0, 0);
        @(posedge clk);
        #1;
        check_outs("post_rst_ld3c", 1, 3, 8'hA5, 0);
        @(negedge clk);
        drive(1, 0, 0, 8'h50, 8'h77, 3'd0, 4'h0, 0);
        @(posedge clk);
        #1;
        check_outs("post_rst_st50", 0, 0, 8'h50, 0);
        @(negedge clk);
        drive(0, 1, 1, 8'h50, 8'h00, 3'd1, 4'h0, 0);
        @(posedge clk);
        #1;
        check_outs("post_rst_ld50", 1, 1, 8'h77, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
